oc_collector_array: RTL and testbench

Parametrised operand-collector array sitting between the register-allocation stage and the ALU/MEM execute pipes. It is the next generation of the fixed 4-unit collector bank. It adds configurable unit count, bank count and operand width, plus:
- internal allocation of free units;
- per-slot operand tracking for bank returns tagged by unit and slot;
- separate ALU and MEM request/grant dispatch with registered outputs;
- flush and error reporting.

---
 rtl/oc_collector_array_if.sv | 61 ++++++
 rtl/oc_collector_array.sv | 232 +++++++++++++++++++++++
 tb/tb_oc_collector_array.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/oc_collector_array_if.sv
// Bus bundle for oc_collector_array: allocation, bank returns, ALU/MEM dispatch
// and status. The master side is the surrounding pipeline; the slave side is the collector.
interface oc_collector_array_if #(
    parameter int unsigned NUM_OC    = 4,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned META_W    = 69
);
    localparam int unsigned OCW = $clog2(NUM_OC);

    logic                        flush;
    logic                        alloc_valid;
    logic [META_W-1:0]           alloc_meta;
    logic                        alloc_is_mem;
    logic [1:0]                  alloc_src_need;
    logic                        alloc_ready;
    logic [OCW-1:0]              alloc_ocid;

    logic [NUM_BANKS-1:0]        bk_vld;
    logic [NUM_BANKS*OCW-1:0]    bk_ocid;
    logic [NUM_BANKS-1:0]        bk_slot;
    logic [NUM_BANKS*DATA_W-1:0] bk_data;

    logic [NUM_OC-1:0]           alu_req;
    logic [NUM_OC-1:0]           mem_req;
    logic [NUM_OC-1:0]           alu_grt;
    logic [NUM_OC-1:0]           mem_grt;

    logic                        alu_out_valid;
    logic [OCW-1:0]              alu_out_ocid;
    logic [META_W-1:0]           alu_out_meta;
    logic [DATA_W-1:0]           alu_out_src0;
    logic [DATA_W-1:0]           alu_out_src1;

    logic                        mem_out_valid;
    logic [OCW-1:0]              mem_out_ocid;
    logic [META_W-1:0]           mem_out_meta;
    logic [DATA_W-1:0]           mem_out_src0;
    logic [DATA_W-1:0]           mem_out_src1;

    logic [OCW:0]                occupancy;
    logic                        err_drop;

    modport master (
        output flush, alloc_valid, alloc_meta, alloc_is_mem, alloc_src_need,
        output bk_vld, bk_ocid, bk_slot, bk_data, alu_grt, mem_grt,
        input  alloc_ready, alloc_ocid, alu_req, mem_req,
        input  alu_out_valid, alu_out_ocid, alu_out_meta, alu_out_src0, alu_out_src1,
        input  mem_out_valid, mem_out_ocid, mem_out_meta, mem_out_src0, mem_out_src1,
        input  occupancy, err_drop
    );

    modport slave (
        input  flush, alloc_valid, alloc_meta, alloc_is_mem, alloc_src_need,
        input  bk_vld, bk_ocid, bk_slot, bk_data, alu_grt, mem_grt,
        output alloc_ready, alloc_ocid, alu_req, mem_req,
        output alu_out_valid, alu_out_ocid, alu_out_meta, alu_out_src0, alu_out_src1,
        output mem_out_valid, mem_out_ocid, mem_out_meta, mem_out_src0, mem_out_src1,
        output occupancy, err_drop
    );
endinterface

// File: rtl/oc_collector_array.sv
// Operand-collector array: allocates free units, gathers tagged bank returns per slot,
// and dispatches READY units to the ALU or MEM pipe through registered output stages.
module oc_collector_array #(
    parameter int unsigned NUM_OC    = 4,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned META_W    = 69
) (
    input  logic                  clk,
    input  logic                  rst,
    oc_collector_array_if.slave   bus
);
    localparam int unsigned OCW  = $clog2(NUM_OC);
    localparam int unsigned CNTW = OCW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    state_t              r_state [NUM_OC];
    logic [1:0]          r_need  [NUM_OC];
    logic [1:0]          r_got   [NUM_OC];
    logic [META_W-1:0]   r_meta  [NUM_OC];
    logic [DATA_W-1:0]   r_src0  [NUM_OC];
    logic [DATA_W-1:0]   r_src1  [NUM_OC];
    logic [NUM_OC-1:0]   r_is_mem;

    logic                r_alu_out_valid;
    logic [OCW-1:0]      r_alu_out_ocid;
    logic [META_W-1:0]   r_alu_out_meta;
    logic [DATA_W-1:0]   r_alu_out_src0;
    logic [DATA_W-1:0]   r_alu_out_src1;
    logic                r_mem_out_valid;
    logic [OCW-1:0]      r_mem_out_ocid;
    logic [META_W-1:0]   r_mem_out_meta;
    logic [DATA_W-1:0]   r_mem_out_src0;
    logic [DATA_W-1:0]   r_mem_out_src1;
    logic [CNTW-1:0]     r_occupancy;
    logic                r_err_drop;

    logic [NUM_OC-1:0]   w_idle;
    logic [NUM_OC-1:0]   w_alu_req;
    logic [NUM_OC-1:0]   w_mem_req;
    logic                w_alloc_ready;
    logic [OCW-1:0]      w_alloc_ocid;
    logic                w_alloc_fire;

    logic [1:0]          w_cap      [NUM_OC];
    logic [DATA_W-1:0]   w_cap_data0[NUM_OC];
    logic [DATA_W-1:0]   w_cap_data1[NUM_OC];
    logic [OCW-1:0]      w_bk_oc;
    logic                w_bk_slot;
    logic                w_drop;

    logic [NUM_OC-1:0]   w_alu_hit;
    logic [NUM_OC-1:0]   w_mem_hit;
    logic [NUM_OC-1:0]   w_alu_win;
    logic [NUM_OC-1:0]   w_mem_win;
    logic                w_alu_fire;
    logic                w_mem_fire;
    logic [OCW-1:0]      w_alu_idx;
    logic [OCW-1:0]      w_mem_idx;
    logic [CNTW-1:0]     w_occ_nxt;

    // State decode: idle map and per-pipe request vectors
    always_comb begin
        w_idle    = '0;
        w_alu_req = '0;
        w_mem_req = '0;
        for (int i = 0; i < NUM_OC; i++) begin
            w_idle[i]    = (r_state[i] == ST_IDLE);
            w_alu_req[i] = (r_state[i] == ST_READY) & ~r_is_mem[i];
            w_mem_req[i] = (r_state[i] == ST_READY) &  r_is_mem[i];
        end
    end

    // Lowest-index idle unit is the allocation target
    always_comb begin
        w_alloc_ocid = '0;
        for (int i = NUM_OC - 1; i >= 0; i--) begin
            if (w_idle[i]) w_alloc_ocid = OCW'(i);
        end
    end

    assign w_alloc_ready = |w_idle;
    assign w_alloc_fire  = bus.alloc_valid & w_alloc_ready & ~bus.flush;

    // Bank returns: lowest bank claims a slot first; anything unusable is a drop
    always_comb begin
        w_drop    = 1'b0;
        w_bk_oc   = '0;
        w_bk_slot = 1'b0;
        for (int i = 0; i < NUM_OC; i++) begin
            w_cap[i]       = '0;
            w_cap_data0[i] = '0;
            w_cap_data1[i] = '0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bk_oc   = bus.bk_ocid[b*OCW +: OCW];
            w_bk_slot = bus.bk_slot[b];
            if (bus.bk_vld[b]) begin
                if ((r_state[w_bk_oc] == ST_COLLECT) && r_need[w_bk_oc][w_bk_slot] &&
                    !r_got[w_bk_oc][w_bk_slot] && !w_cap[w_bk_oc][w_bk_slot]) begin
                    w_cap[w_bk_oc][w_bk_slot] = 1'b1;
                    if (w_bk_slot) w_cap_data1[w_bk_oc] = bus.bk_data[b*DATA_W +: DATA_W];
                    else           w_cap_data0[w_bk_oc] = bus.bk_data[b*DATA_W +: DATA_W];
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
        if (bus.flush) w_drop = 1'b0;
    end

    // Grant arbitration: only honoured bits compete, lowest index wins
    assign w_alu_hit  = bus.alu_grt & w_alu_req;
    assign w_mem_hit  = bus.mem_grt & w_mem_req;
    assign w_alu_win  = w_alu_hit & (~w_alu_hit + NUM_OC'(1));
    assign w_mem_win  = w_mem_hit & (~w_mem_hit + NUM_OC'(1));
    assign w_alu_fire = (|w_alu_hit) & ~bus.flush;
    assign w_mem_fire = (|w_mem_hit) & ~bus.flush;

    always_comb begin
        w_alu_idx = '0;
        w_mem_idx = '0;
        for (int i = 0; i < NUM_OC; i++) begin
            if (w_alu_win[i]) w_alu_idx = OCW'(i);
            if (w_mem_win[i]) w_mem_idx = OCW'(i);
        end
    end

    // Next-cycle busy count so occupancy can be a plain register
    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < NUM_OC; i++) begin
            if (!bus.flush &&
                ((!w_idle[i] && !(w_alu_win[i] | w_mem_win[i])) ||
                 (w_alloc_fire && (w_alloc_ocid == OCW'(i))))) begin
                w_occ_nxt = w_occ_nxt + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_OC; i++) begin
                r_state[i] <= ST_IDLE;
                r_need[i]  <= '0;
                r_got[i]   <= '0;
                r_meta[i]  <= '0;
                r_src0[i]  <= '0;
                r_src1[i]  <= '0;
            end
            r_is_mem        <= '0;
            r_alu_out_valid <= 1'b0;
            r_alu_out_ocid  <= '0;
            r_alu_out_meta  <= '0;
            r_alu_out_src0  <= '0;
            r_alu_out_src1  <= '0;
            r_mem_out_valid <= 1'b0;
            r_mem_out_ocid  <= '0;
            r_mem_out_meta  <= '0;
            r_mem_out_src0  <= '0;
            r_mem_out_src1  <= '0;
            r_occupancy     <= '0;
            r_err_drop      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OC; i++) begin
                if (bus.flush) begin
                    r_state[i] <= ST_IDLE;
                end else if (w_alloc_fire && (w_alloc_ocid == OCW'(i))) begin
                    r_meta[i]   <= bus.alloc_meta;
                    r_is_mem[i] <= bus.alloc_is_mem;
                    r_need[i]   <= bus.alloc_src_need;
                    r_got[i]    <= '0;
                    r_state[i]  <= (bus.alloc_src_need == 2'b00) ? ST_READY : ST_COLLECT;
                end else begin
                    case (r_state[i])
                        ST_COLLECT: begin
                            if (w_cap[i][0]) r_src0[i] <= w_cap_data0[i];
                            if (w_cap[i][1]) r_src1[i] <= w_cap_data1[i];
                            r_got[i] <= r_got[i] | w_cap[i];
                            if ((r_got[i] | w_cap[i]) == r_need[i]) r_state[i] <= ST_READY;
                        end
                        ST_READY: begin
                            if (w_alu_win[i] | w_mem_win[i]) r_state[i] <= ST_IDLE;
                        end
                        default: ;
                    endcase
                end
            end

            r_alu_out_valid <= w_alu_fire;
            if (w_alu_fire) begin
                r_alu_out_ocid <= w_alu_idx;
                r_alu_out_meta <= r_meta[w_alu_idx];
                r_alu_out_src0 <= r_src0[w_alu_idx];
                r_alu_out_src1 <= r_src1[w_alu_idx];
            end
            r_mem_out_valid <= w_mem_fire;
            if (w_mem_fire) begin
                r_mem_out_ocid <= w_mem_idx;
                r_mem_out_meta <= r_meta[w_mem_idx];
                r_mem_out_src0 <= r_src0[w_mem_idx];
                r_mem_out_src1 <= r_src1[w_mem_idx];
            end

            r_occupancy <= w_occ_nxt;
            r_err_drop  <= r_err_drop | w_drop;
        end
    end

    assign bus.alloc_ready   = w_alloc_ready;
    assign bus.alloc_ocid    = w_alloc_ocid;
    assign bus.alu_req       = w_alu_req;
    assign bus.mem_req       = w_mem_req;
    assign bus.alu_out_valid = r_alu_out_valid;
    assign bus.alu_out_ocid  = r_alu_out_ocid;
    assign bus.alu_out_meta  = r_alu_out_meta;
    assign bus.alu_out_src0  = r_alu_out_src0;
    assign bus.alu_out_src1  = r_alu_out_src1;
    assign bus.mem_out_valid = r_mem_out_valid;
    assign bus.mem_out_ocid  = r_mem_out_ocid;
    assign bus.mem_out_meta  = r_mem_out_meta;
    assign bus.mem_out_src0  = r_mem_out_src0;
    assign bus.mem_out_src1  = r_mem_out_src1;
    assign bus.occupancy     = r_occupancy;
    assign bus.err_drop      = r_err_drop;

endmodule

// File: tb/tb_oc_collector_array.sv
// Directed bench for oc_collector_array: allocation, capture, dual dispatch,
// drop/conflict errors, flush and asynchronous reset.
module tb_oc_collector_array;
    localparam int unsigned NUM_OC    = 4;
    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned DATA_W    = 256;
    localparam int unsigned META_W    = 69;
    localparam int unsigned OCW       = 2;

    localparam logic [DATA_W-1:0] DA = {8{32'hAAAA_A0A0}};
    localparam logic [DATA_W-1:0] DB = {8{32'hBBBB_B0B0}};
    localparam logic [DATA_W-1:0] DC = {8{32'hCCCC_C0C0}};
    localparam logic [DATA_W-1:0] DD = {8{32'hDDDD_D0D0}};
    localparam logic [META_W-1:0] META_A = 69'h1_DEAD_BEEF_0000_0001;
    localparam logic [META_W-1:0] META_B = 69'h0_1234_5678_9ABC_DE00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    oc_collector_array_if #(
        .NUM_OC(NUM_OC), .NUM_BANKS(NUM_BANKS), .DATA_W(DATA_W), .META_W(META_W)
    ) bus ();

    oc_collector_array #(
        .NUM_OC(NUM_OC), .NUM_BANKS(NUM_BANKS), .DATA_W(DATA_W), .META_W(META_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.flush          = 1'b0;
        bus.alloc_valid    = 1'b0;
        bus.alloc_meta     = '0;
        bus.alloc_is_mem   = 1'b0;
        bus.alloc_src_need = 2'b00;
        bus.bk_vld         = '0;
        bus.bk_ocid        = '0;
        bus.bk_slot        = '0;
        bus.bk_data        = '0;
        bus.alu_grt        = '0;
        bus.mem_grt        = '0;
    endtask

    task automatic do_alloc(input logic [META_W-1:0] meta, input logic is_mem, input logic [1:0] need);
        bus.alloc_valid    = 1'b1;
        bus.alloc_meta     = meta;
        bus.alloc_is_mem   = is_mem;
        bus.alloc_src_need = need;
    endtask

    task automatic bank(input int b, input int oc, input logic slot, input logic [DATA_W-1:0] d);
        bus.bk_vld[b]                = 1'b1;
        bus.bk_ocid[b*OCW +: OCW]    = OCW'(oc);
        bus.bk_slot[b]               = slot;
        bus.bk_data[b*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_alloc_ocid", bus.alloc_ocid, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_err_drop", bus.err_drop, 0);
        chk("rst_alu_valid", bus.alu_out_valid, 0);
        chk("rst_mem_valid", bus.mem_out_valid, 0);
        rst = 1'b1;

        // Basic alloc, two-bank capture at t+3, dispatch
        do_alloc(META_A, 1'b0, 2'b11);
        tick(); clear_in();
        chk("t1_occ", bus.occupancy, 1);
        chk("t1_req_early", bus.alu_req, 4'b0000);
        tick(); tick();
        bank(0, 0, 1'b0, DA);
        bank(2, 0, 1'b1, DB);
        tick(); clear_in();
        chk("t1_req", bus.alu_req, 4'b0001);
        chk("t1_err", bus.err_drop, 0);
        bus.alu_grt = 4'b0001;
        tick(); clear_in();
        chk("t1_valid", bus.alu_out_valid, 1);
        chk("t1_ocid", bus.alu_out_ocid, 0);
        chk("t1_src0", bus.alu_out_src0, DA);
        chk("t1_src1", bus.alu_out_src1, DB);
        chk("t1_meta", bus.alu_out_meta, META_A);
        chk("t1_occ_after", bus.occupancy, 0);
        tick();
        chk("t1_valid_drop", bus.alu_out_valid, 0);

        // Fill all units; unit 3 goes to MEM
        for (int k = 0; k < 4; k++) begin
            chk("t2_alloc_ocid", bus.alloc_ocid, DATA_W'(k));
            do_alloc(META_B ^ META_W'(k), (k == 3), 2'b00);
            tick();
        end
        clear_in();
        chk("t2_ready_full", bus.alloc_ready, 0);
        chk("t2_occ_full", bus.occupancy, 4);
        chk("t2_alu_req", bus.alu_req, 4'b0111);
        chk("t2_mem_req", bus.mem_req, 4'b1000);
        bus.alu_grt = 4'b0100;
        tick(); clear_in();
        chk("t2_g_ocid", bus.alu_out_ocid, 2);
        chk("t2_g_meta", bus.alu_out_meta, META_B ^ META_W'(2));
        chk("t2_ready_free", bus.alloc_ready, 1);
        chk("t2_ocid_free", bus.alloc_ocid, 2);
        chk("t2_occ_3", bus.occupancy, 3);

        // Dual dispatch; mem_grt bit 0 has no matching request
        bus.alu_grt = 4'b0010;
        bus.mem_grt = 4'b1001;
        tick(); clear_in();
        chk("t3_alu_valid", bus.alu_out_valid, 1);
        chk("t3_alu_ocid", bus.alu_out_ocid, 1);
        chk("t3_mem_valid", bus.mem_out_valid, 1);
        chk("t3_mem_ocid", bus.mem_out_ocid, 3);
        chk("t3_mem_meta", bus.mem_out_meta, META_B ^ META_W'(3));
        chk("t3_occ", bus.occupancy, 1);
        chk("t3_alu_req", bus.alu_req, 4'b0001);
        chk("t3_mem_req", bus.mem_req, 4'b0000);
        bus.alu_grt = 4'b0001;
        tick(); clear_in();
        chk("t3_occ_empty", bus.occupancy, 0);
        chk("t3_mem_valid_off", bus.mem_out_valid, 0);

        // need = 00 requests one cycle after alloc
        do_alloc(META_A, 1'b0, 2'b00);
        tick(); clear_in();
        chk("t4_need00_req", bus.alu_req, 4'b0001);
        bus.alu_grt = 4'b0001;
        tick(); clear_in();

        // need = 10: slot0 return is a drop, slot1 completes
        do_alloc(META_A, 1'b0, 2'b10);
        tick(); clear_in();
        chk("t4_err_clean", bus.err_drop, 0);
        bank(0, 0, 1'b0, DC);
        tick(); clear_in();
        chk("t4_err_slot0", bus.err_drop, 1);
        chk("t4_req_wait", bus.alu_req, 4'b0000);
        bank(1, 0, 1'b1, DD);
        tick(); clear_in();
        chk("t4_req", bus.alu_req, 4'b0001);
        bus.alu_grt = 4'b0001;
        tick(); clear_in();
        chk("t4_src1", bus.alu_out_src1, DD);

        rst = 1'b0;
        tick();
        chk("rst2_err", bus.err_drop, 0);
        rst = 1'b1;

        // Same-slot conflict between banks 1 and 3, plus slot1 from bank 0
        do_alloc(META_A, 1'b0, 2'b11);
        tick(); clear_in();
        bank(1, 0, 1'b0, DA);
        bank(3, 0, 1'b0, DB);
        bank(0, 0, 1'b1, DC);
        tick(); clear_in();
        chk("t5_err", bus.err_drop, 1);
        chk("t5_req", bus.alu_req, 4'b0001);
        bus.alu_grt = 4'b0001;
        tick(); clear_in();
        chk("t5_src0", bus.alu_out_src0, DA);
        chk("t5_src1", bus.alu_out_src1, DC);

        // Multi-hot grant
        for (int k = 0; k < 3; k++) begin
            do_alloc(META_B, 1'b0, 2'b00);
            tick();
        end
        clear_in();
        chk("t6_req", bus.alu_req, 4'b0111);
        bus.alu_grt = 4'b0110;
        tick(); clear_in();
        chk("t6_ocid", bus.alu_out_ocid, 1);
        chk("t6_req_left", bus.alu_req, 4'b0101);

        // Flush: clear, refill three collecting units, flush with competing activity
        bus.flush = 1'b1;
        tick(); clear_in();
        chk("t7_occ_flush1", bus.occupancy, 0);
        for (int k = 0; k < 3; k++) begin
            do_alloc(META_A, 1'b0, 2'b11);
            tick();
        end
        clear_in();
        chk("t7_occ_busy", bus.occupancy, 3);
        bus.flush = 1'b1;
        do_alloc(META_A, 1'b0, 2'b00);
        bank(0, 0, 1'b0, DA);
        tick(); clear_in();
        chk("t7_occ", bus.occupancy, 0);
        chk("t7_ready", bus.alloc_ready, 1);
        chk("t7_alu_valid", bus.alu_out_valid, 0);
        chk("t7_mem_valid", bus.mem_out_valid, 0);
        chk("t7_err_kept", bus.err_drop, 1);
        chk("t7_req", bus.alu_req, 4'b0000);

        // Asynchronous reset mid-cycle
        do_alloc(META_A, 1'b0, 2'b00);
        tick(); clear_in();
        bus.alu_grt = 4'b0001;
        tick(); clear_in();
        chk("t8_valid_pre", bus.alu_out_valid, 1);
        #3 rst = 1'b0;
        #1;
        chk("t8_valid", bus.alu_out_valid, 0);
        chk("t8_occ", bus.occupancy, 0);
        chk("t8_ready", bus.alloc_ready, 1);
        chk("t8_err", bus.err_drop, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
